// File: rtl/spectrum_pkg.sv
// Shared spectrum-analyzer definitions: loader state encoding, default RAM geometry
// and a bit-reverse helper sized for the default address width.
package spectrum_pkg;

  localparam int RAM_WIDTH_DEF     = 18;
  localparam int RAM_ADDR_BITS_DEF = 10;
  localparam int SAMPLE_WIDTH_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    FLUSH   = 2'd2,
    HANDOFF = 2'd3
  } loaderState_e;

  function automatic logic [RAM_ADDR_BITS_DEF-1:0] bitReverse(
    input logic [RAM_ADDR_BITS_DEF-1:0] value
  );
    logic [RAM_ADDR_BITS_DEF-1:0] result;
    result = '0;
    for (int i = 0; i < RAM_ADDR_BITS_DEF; i++) begin
      result[i] = value[RAM_ADDR_BITS_DEF-1-i];
    end
    return result;
  endfunction

endpackage

// File: rtl/bit_reverse.sv
// Pure combinational bit-order reversal over a parameterized width; used to produce
// decimation-in-time RAM addresses from the natural sample index.
module bit_reverse #(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  for (genvar i = 0; i < WIDTH; i++) begin : gRev
    assign dout[i] = din[WIDTH-1-i];
  end

endmodule

// File: rtl/fft_sample_loader.sv
// Streams one frame of ADC samples into the FFT input RAM (port A) and hands the frame
// to the FFT controller. Define FFT_BITREV_EN for bit-reversed write addressing.
module fft_sample_loader
  import spectrum_pkg::*;
#(
  parameter int RAM_WIDTH     = RAM_WIDTH_DEF,
  parameter int RAM_ADDR_BITS = RAM_ADDR_BITS_DEF,
  parameter int SAMPLE_WIDTH  = SAMPLE_WIDTH_DEF
) (
  input  logic                     Clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     sample_valid,
  input  logic [SAMPLE_WIDTH-1:0]  sample_data,
  output logic                     sample_ready,
  output logic [RAM_ADDR_BITS-1:0] ram_addr,
  output logic [RAM_WIDTH-1:0]     ram_din,
  output logic                     ram_we,
  output logic                     frame_ready,
  input  logic                     frame_ack,
  output logic                     overrun,
  output loaderState_e             dbgState
);

  // Handshake: a sample moves when sample_valid && sample_ready are both high at a
  // rising edge; sample_ready is registered and only high in FILL. Offers made while
  // not ready are dropped and flagged on the sticky overrun output.

  loaderState_e state, stateNext;
  logic [RAM_ADDR_BITS-1:0] count;
  logic [RAM_ADDR_BITS-1:0] writeAddr;
  logic [1:0]               flushCnt;
  logic [RAM_WIDTH-1:0]     dataPipe;
  logic                     wePipe;
  logic signed [RAM_WIDTH-1:0] sampleExt;
  logic transfer;
  logic lastTransfer;
  logic startAccepted;

  assign transfer      = sample_valid && sample_ready;
  assign lastTransfer  = transfer && (count == {RAM_ADDR_BITS{1'b1}});
  assign startAccepted = (state == IDLE) && start;
  assign sampleExt     = RAM_WIDTH'($signed(sample_data));
  assign dbgState      = state;

`ifdef FFT_BITREV_EN
  bit_reverse #(.WIDTH(RAM_ADDR_BITS)) uBitReverse (
    .din  (count),
    .dout (writeAddr)
  );
`else
  assign writeAddr = count;
`endif

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start)          stateNext = FILL;
      FILL:    if (lastTransfer)   stateNext = FLUSH;
      // Hold until the last word has been committed by the RAM.
      FLUSH:   if (flushCnt == 2'd2) stateNext = HANDOFF;
      HANDOFF: if (frame_ack)      stateNext = IDLE;
      default:                     stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      count        <= '0;
      flushCnt     <= '0;
      dataPipe     <= '0;
      wePipe       <= 1'b0;
      sample_ready <= 1'b0;
      ram_addr     <= '0;
      ram_din      <= '0;
      ram_we       <= 1'b0;
      frame_ready  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= stateNext;
      sample_ready <= (stateNext == FILL);
      frame_ready  <= (stateNext == HANDOFF);
      flushCnt     <= (state == FLUSH) ? flushCnt + 2'd1 : 2'd0;

      if (startAccepted)  count <= '0;
      else if (transfer)  count <= count + RAM_ADDR_BITS'(1);

      // Address goes out on the transfer edge; data and write enable follow one edge later.
      if (transfer) begin
        ram_addr <= writeAddr;
        dataPipe <= sampleExt;
      end
      wePipe <= transfer;
      ram_we <= wePipe;
      if (wePipe) ram_din <= dataPipe;

      if (startAccepted)                     overrun <= 1'b0;
      else if (sample_valid && !sample_ready) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_sample_loader.sv
// Scoreboard bench for fft_sample_loader: random frames, a RAM emulation on the write
// port, and an address/data reference computed from the sample index.
module tb_fft_sample_loader;
  import spectrum_pkg::*;

  localparam int AB = 10;
  localparam int RW = 18;
  localparam int SW = 16;
  localparam int N  = 1 << AB;
  localparam int W  = AB + RW;

  logic          Clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          sample_valid = 1'b0;
  logic [SW-1:0] sample_data = '0;
  logic          sample_ready;
  logic [AB-1:0] ram_addr;
  logic [RW-1:0] ram_din;
  logic          ram_we;
  logic          frame_ready;
  logic          frame_ack = 1'b0;
  logic          overrun;
  loaderState_e  dbgState;

  fft_sample_loader #(
    .RAM_WIDTH     (RW),
    .RAM_ADDR_BITS (AB),
    .SAMPLE_WIDTH  (SW)
  ) dut (
    .Clk          (Clk),
    .reset        (reset),
    .start        (start),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .sample_ready (sample_ready),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_we       (ram_we),
    .frame_ready  (frame_ready),
    .frame_ack    (frame_ack),
    .overrun      (overrun),
    .dbgState     (dbgState)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  logic [W-1:0]  exp_q[$];
  logic [RW-1:0] ramModel [N];
  logic [AB-1:0] prevAddr = '0;
  int            writeCnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: RAM location and word for sample index k / value s
  function automatic int refAddr(input int k);
    int r = 0;
    int v = k;
`ifdef FFT_BITREV_EN
    for (int i = 0; i < AB; i++) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
`else
    r = v;
    return r;
`endif
  endfunction

  function automatic logic [RW-1:0] refData(input logic [SW-1:0] s);
    int v;
    v = int'(s);
    if (v >= (1 << (SW - 1))) v = v - (1 << SW);
    return v[RW-1:0];
  endfunction

  // monitor: emulates the RAM port (address captured a cycle ahead of data/we)
  always @(negedge Clk) begin
    logic [W-1:0] e;
    if (!reset) begin
      prevAddr = '0;
    end else begin
      if (ram_we) begin
        writeCnt++;
        if (exp_q.size() == 0) begin
          check("write_without_expected", 32'(ram_we), 0);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", 32'(prevAddr), 32'(e[W-1:RW]));
          check("write_data", 32'(ram_din), 32'(e[RW-1:0]));
          ramModel[prevAddr] = ram_din;
        end
      end
      prevAddr = ram_addr;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [SW-1:0] d, input int idx);
    sample_valid = 1'b1;
    sample_data  = d;
    check("sample_ready", 32'(sample_ready), 1);
    exp_q.push_back({AB'(refAddr(idx)), refData(d)});
    tick();
    sample_valid = 1'b0;
  endtask

  // mode 0: value=index, 1: random back-to-back, 2: valid toggling, 3: random gaps
  task automatic run_frame(input int mode, input int ackAt, input int startAt);
    int w0;
    logic [SW-1:0] d;
    w0 = writeCnt;
    for (int k = 0; k < N; k++) begin
      d = (mode == 0) ? SW'(k) : SW'($urandom);
      if (mode != 0 && k == 5) d = 16'h8000;
      if (mode != 0 && k == 6) d = 16'h7FFF;
      frame_ack = (k == ackAt);
      start     = (k == startAt);
      send(d, k);
      frame_ack = 1'b0;
      start     = 1'b0;
      if (k != N - 1) begin
        if (mode == 2) tick();
        if (mode == 3) repeat ($urandom_range(0, 2)) tick();
      end
    end
    check("ready_after_last", 32'(sample_ready), 0);
    check("frame_ready_e0", 32'(frame_ready), 0);
    tick();
    check("frame_ready_e1", 32'(frame_ready), 0);
    tick();
    check("frame_ready_e2", 32'(frame_ready), 0);
    tick();
    check("frame_ready_e3", 32'(frame_ready), 1);
    check("writes_per_frame", 32'(writeCnt - w0), N);
    check("queue_drained", 32'(exp_q.size()), 0);
  endtask

  task automatic ack_frame();
    repeat (3) tick();
    check("frame_ready_held", 32'(frame_ready), 1);
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    tick();
    check("frame_ready_after_ack", 32'(frame_ready), 0);
    check("state_after_ack", 32'(dbgState), 32'(IDLE));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_sample_ready"}, 32'(sample_ready), 0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 0);
    check({tag, "_ram_din"}, 32'(ram_din), 0);
    check({tag, "_ram_we"}, 32'(ram_we), 0);
    check({tag, "_frame_ready"}, 32'(frame_ready), 0);
    check({tag, "_overrun"}, 32'(overrun), 0);
    check({tag, "_state"}, 32'(dbgState), 32'(IDLE));
  endtask

  initial begin
    int k;
    repeat (2) tick();
    check_reset_values("reset");
    reset = 1'b1;
    tick();

    // offer in IDLE: overrun, no write
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    check("overrun_idle", 32'(overrun), 1);
    tick();
    check("overrun_sticky", 32'(overrun), 1);

    // frame 1: value = index, early ack ignored
    do_start();
    check("overrun_cleared_by_start", 32'(overrun), 0);
    run_frame(0, 100, -1);
    check("ram_word_idx1", 32'(ramModel[refAddr(1)]), 1);
    check("ram_word_idx1023", 32'(ramModel[refAddr(1023)]), 1023);
    for (int i = 0; i < 4; i++) begin
      k = $urandom_range(0, N - 1);
      check("ram_word_rand", 32'(ramModel[refAddr(k)]), 32'(k));
    end

    // offer in HANDOFF
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    check("overrun_handoff", 32'(overrun), 1);
    check("frame_ready_handoff", 32'(frame_ready), 1);
    ack_frame();

    // start and an offer in the same IDLE cycle: clear wins
    sample_valid = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    sample_valid = 1'b0;
    check("overrun_clear_wins", 32'(overrun), 0);
    run_frame(2, -1, -1);
    check("ram_word_min", 32'(ramModel[refAddr(5)]), 32'h38000);
    check("ram_word_max", 32'(ramModel[refAddr(6)]), 32'h07FFF);
    ack_frame();

    // random gaps, stray start mid-frame
    do_start();
    run_frame(3, -1, 200);
    ack_frame();

    // reset after 300 transfers
    do_start();
    for (int i = 0; i < 300; i++) send(SW'($urandom), i);
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("midreset");
    exp_q.delete();
    @(posedge Clk);
    #1;
    reset = 1'b1;
    repeat (3) tick();
    check("no_frame_after_abort", 32'(frame_ready), 0);
    check("no_write_after_abort", 32'(ram_we), 0);
    do_start();
    run_frame(1, -1, -1);
    check("ram_word_min_r", 32'(ramModel[refAddr(5)]), 32'h38000);
    ack_frame();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
